hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed two-source hazard and forwarding logic of the 5-stage pipeline.
- Tracks every in-flight destination across DEPTH post-ID stages, with per-instruction result latency (ALU, LOAD, multi-cycle MUL).
- Generates the ID-stage stall, the EX-stage operand forwarding selects, and a structural stall for the non-pipelined multiplier.
- Sits beside the ID/EX pipeline registers; drives PC/IF2ID write-enables and the EX operand muxes.

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/fwd_select.sv | 33 +++
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
// Every tracked stage carries one entry_t describing the instruction it holds.
package hazard_pkg;

  localparam int MAX_AW  = 8;
  localparam int AVAIL_W = 8;

  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_LOAD = 2'd1;
  localparam logic [1:0] KIND_MUL  = 2'd2;

  typedef struct packed {
    logic               valid;
    logic               wb;
    logic [MAX_AW-1:0]  dest;
    logic [AVAIL_W-1:0] avail;
    logic [MAX_AW-1:0]  rs;
    logic [MAX_AW-1:0]  rt;
    logic               use_rs;
    logic               use_rt;
  } entry_t;

  // Stage number at whose end the result exists; the reserved kind behaves like an ALU op.
  function automatic logic [AVAIL_W-1:0] avail_of(input logic [1:0] kind, input int mul_lat);
    logic [AVAIL_W-1:0] lat;
    case (kind)
      KIND_LOAD: lat = AVAIL_W'(2);
      KIND_MUL:  lat = AVAIL_W'(mul_lat);
      default:   lat = AVAIL_W'(1);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority search over stages 2..DEPTH for the youngest producer of one EX operand.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FW    = $clog2(DEPTH + 1)
) (
  input  logic               ex_valid,
  input  logic               use_src,
  input  logic [MAX_AW-1:0]  src,
  input  logic [DEPTH:2]     cand_wb,
  input  logic [MAX_AW-1:0]  cand_dest  [2:DEPTH],
  input  logic [AVAIL_W-1:0] cand_avail [2:DEPTH],
  output logic [FW-1:0]      sel
);

  logic found;

  // The youngest match always ends the search; if its result is not ready yet it forwards nothing.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    if (ex_valid && use_src) begin
      for (int s = 2; s <= DEPTH; s++) begin
        if (!found && cand_wb[s] && cand_dest[s] == src && cand_dest[s] != '0) begin
          found = 1'b1;
          if (AVAIL_W'(s) > cand_avail[s]) sel = FW'(s);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destinations across DEPTH post-ID stages and derives the ID stall,
// the multiplier structural stall and the EX operand forwarding selects. DEPTH must be >= MUL_LAT+1.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 3,
  parameter int FW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb,
  input  logic [1:0]        id_kind,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic              ex_valid
);

  entry_t             stage_q [1:DEPTH];
  entry_t             stage_d [1:DEPTH];
  logic [AVAIL_W-1:0] mcnt_q;
  logic [AVAIL_W-1:0] mcnt_d;

  logic [MAX_AW-1:0]  rs_ext;
  logic [MAX_AW-1:0]  rt_ext;
  logic [MAX_AW-1:0]  dest_ext;
  logic               is_mul;
  logic               data_hz;
  logic               struct_hz;

  logic [DEPTH:2]     cand_wb;
  logic [MAX_AW-1:0]  cand_dest  [2:DEPTH];
  logic [AVAIL_W-1:0] cand_avail [2:DEPTH];

  assign rs_ext   = MAX_AW'(id_rs);
  assign rt_ext   = MAX_AW'(id_rt);
  assign dest_ext = MAX_AW'(id_dest);
  assign is_mul   = (id_kind == KIND_MUL);

  // A producer at stage s would sit at s+1 when the consumer reaches EX; it needs s+1 > avail.
  always_comb begin
    data_hz = 1'b0;
    for (int s = 1; s <= DEPTH; s++) begin
      if (stage_q[s].valid && stage_q[s].wb && stage_q[s].dest != '0 &&
          ((id_use_rs && stage_q[s].dest == rs_ext) || (id_use_rt && stage_q[s].dest == rt_ext)) &&
          AVAIL_W'(s) < stage_q[s].avail)
        data_hz = 1'b1;
    end
  end

  assign struct_hz = is_mul && (mcnt_q != '0);
  assign stall     = id_valid && !flush && (data_hz || struct_hz);
  assign issue     = id_valid && !flush && !stall;
  assign ex_valid  = stage_q[1].valid;

  always_comb begin
    stage_d[1] = '0;
    if (issue) begin
      stage_d[1].valid  = 1'b1;
      stage_d[1].wb     = id_wb;
      stage_d[1].dest   = dest_ext;
      stage_d[1].avail  = avail_of(id_kind, MUL_LAT);
      stage_d[1].rs     = rs_ext;
      stage_d[1].rt     = rt_ext;
      stage_d[1].use_rs = id_use_rs;
      stage_d[1].use_rt = id_use_rt;
    end
    for (int s = 2; s <= DEPTH; s++) stage_d[s] = stage_q[s-1];

    mcnt_d = mcnt_q;
    if (issue && is_mul)   mcnt_d = AVAIL_W'(MUL_LAT - 1);
    else if (mcnt_q != '0) mcnt_d = mcnt_q - AVAIL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 1; s <= DEPTH; s++) stage_q[s] <= '0;
      mcnt_q <= '0;
    end else begin
      stage_q <= stage_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    cand_wb = '0;
    for (int s = 2; s <= DEPTH; s++) begin
      cand_wb[s]    = stage_q[s].valid && stage_q[s].wb;
      cand_dest[s]  = stage_q[s].dest;
      cand_avail[s] = stage_q[s].avail;
    end
  end

  fwd_select #(.DEPTH(DEPTH), .FW(FW)) u_fwd_a (
    .ex_valid   (stage_q[1].valid),
    .use_src    (stage_q[1].use_rs),
    .src        (stage_q[1].rs),
    .cand_wb    (cand_wb),
    .cand_dest  (cand_dest),
    .cand_avail (cand_avail),
    .sel        (fwd_a)
  );

  fwd_select #(.DEPTH(DEPTH), .FW(FW)) u_fwd_b (
    .ex_valid   (stage_q[1].valid),
    .use_src    (stage_q[1].use_rt),
    .src        (stage_q[1].rt),
    .cand_wb    (cand_wb),
    .cand_dest  (cand_dest),
    .cand_avail (cand_avail),
    .sel        (fwd_b)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a timestamp-based model of in-flight instructions
// is compared with the DUT every cycle, plus hand-computed literals at key points.
module tb_hazard_scoreboard;

  localparam int REG_AW  = 5;
  localparam int DEPTH   = 4;
  localparam int MUL_LAT = 3;
  localparam int FW      = $clog2(DEPTH + 1);

  localparam logic [1:0] K_ALU  = 2'd0;
  localparam logic [1:0] K_LOAD = 2'd1;
  localparam logic [1:0] K_MUL  = 2'd2;
  localparam logic [1:0] K_RSV  = 2'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_rs = '0;
  logic [REG_AW-1:0] id_rt = '0;
  logic              id_use_rs = 1'b0;
  logic              id_use_rt = 1'b0;
  logic [REG_AW-1:0] id_dest = '0;
  logic              id_wb = 1'b0;
  logic [1:0]        id_kind = '0;
  logic              flush = 1'b0;
  logic              stall;
  logic              issue;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic              ex_valid;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .FW(FW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wb(id_wb),
    .id_kind(id_kind), .flush(flush), .stall(stall), .issue(issue),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_valid(ex_valid)
  );

  // Each issued instruction is remembered by the cycle it left ID; its stage is the age in cycles.
  typedef struct {
    int         id_cycle;
    logic [4:0] dest;
    logic       wb;
    int         lat;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } rec_t;

  rec_t inflight[$];
  int   cyc      = 0;
  int   last_mul = -1000;
  int   errors   = 0;
  int   checks   = 0;
  int   m_stall, m_issue, m_fa, m_fb, m_exv;

  function automatic int lat_of(input logic [1:0] k);
    if (k == K_LOAD) return 2;
    if (k == K_MUL)  return MUL_LAT;
    return 1;
  endfunction

  function automatic int fwd_of(input int ex_idx, input logic [4:0] src, input logic u);
    if (ex_idx < 0 || !u || src == 5'd0) return 0;
    for (int s = 2; s <= DEPTH; s++)
      foreach (inflight[i])
        if (cyc - inflight[i].id_cycle == s && inflight[i].wb && inflight[i].dest == src)
          return (s > inflight[i].lat) ? s : 0;
    return 0;
  endfunction

  task automatic compute_model(output int e_stall, output int e_issue, output int e_fa,
                               output int e_fb, output int e_exv);
    int data_hz = 0;
    int struct_hz;
    int ex_idx = -1;
    foreach (inflight[i]) begin
      int s;
      s = cyc - inflight[i].id_cycle;
      if (s == 1) ex_idx = i;
      if (s >= 1 && s <= DEPTH && inflight[i].wb && inflight[i].dest != 5'd0 &&
          ((id_use_rs && inflight[i].dest == id_rs) || (id_use_rt && inflight[i].dest == id_rt)) &&
          s < inflight[i].lat)
        data_hz = 1;
    end
    struct_hz = (id_kind == K_MUL && cyc < last_mul + MUL_LAT) ? 1 : 0;
    e_stall = (id_valid && !flush && (data_hz != 0 || struct_hz != 0)) ? 1 : 0;
    e_issue = (id_valid && !flush && e_stall == 0) ? 1 : 0;
    e_exv   = (ex_idx >= 0) ? 1 : 0;
    e_fa    = (ex_idx >= 0) ? fwd_of(ex_idx, inflight[ex_idx].rs, inflight[ex_idx].use_rs) : 0;
    e_fb    = (ex_idx >= 0) ? fwd_of(ex_idx, inflight[ex_idx].rt, inflight[ex_idx].use_rt) : 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    compute_model(m_stall, m_issue, m_fa, m_fb, m_exv);
    chk("stall", int'(stall), m_stall);
    chk("issue", int'(issue), m_issue);
    chk("fwd_a", int'(fwd_a), m_fa);
    chk("fwd_b", int'(fwd_b), m_fb);
    chk("ex_valid", int'(ex_valid), m_exv);
  endtask

  task automatic update_model();
    rec_t r;
    if (rst) begin
      inflight.delete();
      last_mul = -1000;
    end else if (m_issue != 0) begin
      r.id_cycle = cyc;
      r.dest = id_dest;  r.wb = id_wb;  r.lat = lat_of(id_kind);
      r.rs = id_rs;      r.rt = id_rt;
      r.use_rs = id_use_rs;  r.use_rt = id_use_rt;
      inflight.push_back(r);
      if (id_kind == K_MUL) last_mul = cyc;
    end
    while (inflight.size() > 0 && cyc + 1 - inflight[0].id_cycle > DEPTH) void'(inflight.pop_front());
    cyc++;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] dest,
                               input logic wb, input logic [1:0] kind, input logic fl,
                               input logic r);
    id_valid = v;  id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;
    id_dest = dest;  id_wb = wb;  id_kind = kind;  flush = fl;  rst = r;
  endtask

  // One clock: drive after the edge, compare at the falling edge, advance the model.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] dest,
                      input logic wb, input logic [1:0] kind, input logic fl, input logic r);
    @(posedge clk);
    #1;
    applyStimulus(v, rs, rt, urs, urt, dest, wb, kind, fl, r);
    @(negedge clk);
    checkOutput();
    update_model();
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, K_ALU, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (DEPTH) nop();
  endtask

  task automatic ins(input logic [1:0] kind, input logic [4:0] dest, input logic [4:0] rs,
                     input logic [4:0] rt, input logic urs, input logic urt);
    step(1'b1, rs, rt, urs, urt, dest, 1'b1, kind, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with a MUL presented in ID: nothing tracked, so it would issue.
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, K_MUL, 1'b0, 1'b1);
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, K_MUL, 1'b0, 1'b1);
    chk("rst_stall", int'(stall), 0);
    chk("rst_issue", int'(issue), 1);
    chk("rst_fwd_a", int'(fwd_a), 0);
    chk("rst_fwd_b", int'(fwd_b), 0);
    chk("rst_ex_valid", int'(ex_valid), 0);
    nop();

    // ALU -> ALU back to back
    ins(K_ALU, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1);  chk("alu_p_stall", int'(stall), 0);
    ins(K_ALU, 5'd4, 5'd3, 5'd1, 1'b1, 1'b1);  chk("alu_c_stall", int'(stall), 0);
    nop();
    chk("alu_fwd_a", int'(fwd_a), 2);
    chk("alu_fwd_b", int'(fwd_b), 0);
    chk("alu_model_fa", m_fa, 2);
    drain();

    // LOAD -> use: one bubble
    ins(K_LOAD, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0);
    ins(K_ALU, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1);
    chk("ld_stall", int'(stall), 1);
    chk("ld_issue_hold", int'(issue), 0);
    chk("ld_model_stall", m_stall, 1);
    ins(K_ALU, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1);
    chk("ld_stall_done", int'(stall), 0);
    chk("ld_bubble", int'(ex_valid), 0);
    nop();
    chk("ld_fwd_a", int'(fwd_a), 3);
    chk("ld_fwd_b", int'(fwd_b), 3);
    drain();

    // MUL -> dependent ALU on rt
    ins(K_MUL, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1);
    ins(K_ALU, 5'd9, 5'd1, 5'd7, 1'b1, 1'b1);  chk("mul_dep_stall1", int'(stall), 1);
    ins(K_ALU, 5'd9, 5'd1, 5'd7, 1'b1, 1'b1);  chk("mul_dep_stall2", int'(stall), 1);
    ins(K_ALU, 5'd9, 5'd1, 5'd7, 1'b1, 1'b1);  chk("mul_dep_go", int'(stall), 0);
    nop();
    chk("mul_fwd_b", int'(fwd_b), 4);
    chk("mul_fwd_a", int'(fwd_a), 0);
    chk("mul_model_fb", m_fb, 4);
    drain();

    // Independent MULs: structural hazard only
    ins(K_MUL, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1);
    ins(K_MUL, 5'd9, 5'd2, 5'd3, 1'b1, 1'b1);  chk("mcnt2_stall", int'(stall), 1);
    ins(K_MUL, 5'd9, 5'd2, 5'd3, 1'b1, 1'b1);  chk("mcnt1_stall", int'(stall), 1);
    ins(K_MUL, 5'd9, 5'd2, 5'd3, 1'b1, 1'b1);
    chk("mcnt0_stall", int'(stall), 0);
    chk("mcnt0_issue", int'(issue), 1);
    drain();

    // r0 is never a hazard
    ins(K_LOAD, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0);
    ins(K_ALU, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1);  chk("r0_stall", int'(stall), 0);
    nop();
    chk("r0_fwd_a", int'(fwd_a), 0);
    chk("r0_fwd_b", int'(fwd_b), 0);
    drain();

    // Three writers of r5: youngest wins
    ins(K_LOAD, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0);
    ins(K_ALU, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
    ins(K_ALU, 5'd5, 5'd2, 5'd1, 1'b1, 1'b1);
    ins(K_ALU, 5'd10, 5'd5, 5'd2, 1'b1, 1'b1);  chk("young_stall", int'(stall), 0);
    nop();
    chk("young_fwd_a", int'(fwd_a), 2);
    chk("young_fwd_b", int'(fwd_b), 0);
    drain();

    // Reserved kind behaves as ALU
    ins(K_RSV, 5'd12, 5'd1, 5'd2, 1'b1, 1'b1);
    ins(K_ALU, 5'd13, 5'd12, 5'd1, 1'b1, 1'b1);  chk("rsv_stall", int'(stall), 0);
    nop();
    chk("rsv_fwd_a", int'(fwd_a), 2);
    drain();

    // Flush wins over the load-use stall
    ins(K_LOAD, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, K_ALU, 1'b1, 1'b0);
    chk("flush_stall", int'(stall), 0);
    chk("flush_issue", int'(issue), 0);
    nop();
    chk("flush_bubble", int'(ex_valid), 0);

    // Reset with a MUL and an ALU in flight
    ins(K_MUL, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1);
    ins(K_ALU, 5'd4, 5'd3, 5'd1, 1'b1, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, K_ALU, 1'b0, 1'b1);
    ins(K_MUL, 5'd11, 5'd1, 5'd2, 1'b1, 1'b1);
    chk("mrst_stall", int'(stall), 0);
    chk("mrst_issue", int'(issue), 1);
    chk("mrst_ex_valid", int'(ex_valid), 0);
    chk("mrst_fwd_a", int'(fwd_a), 0);
    nop();
    chk("mrst_ex_mul", int'(ex_valid), 1);
    chk("mrst_fwd_b", int'(fwd_b), 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
